// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Decodes a 7-bit host command bus into UART transmit-side control:
// a one-byte transmit holding register with overflow detection, a
// programmable baud prescaler, an enable bit and a soft-reset command.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous active-high reset
//   in7[6:0]            host command bus: cmd=[1:0], half=[6], nib=[5:2]
//   tx_data[7:0]        holding-register byte for the transmitter
//   tx_valid            holding register full
//   tx_ready            transmitter accepts tx_data this cycle
//   baud_tick           registered one-cycle prescaler pulse
//   enable              UART enable
//   overflow            sticky flag: a byte was dropped on a full register
//   resetCommandStrobe  one-cycle pulse after a soft-reset command executes
module uart_cmd_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] in7,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       baud_tick,
    output logic       enable,
    output logic       overflow,
    output logic       resetCommandStrobe
);

    localparam logic [1:0] CMD_DATA   = 2'd0;
    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_PREDIV = 2'd2;
    localparam logic [1:0] CMD_SPARE  = 2'd3;

    localparam logic [6:0] BUS_IDLE   = 7'h7F;

    localparam logic [4:0] ARG_SOFT_RST = 5'b11000;
    localparam logic [4:0] ARG_CLR_OVF  = 5'b00001;
    localparam logic [4:0] ARG_ENABLE   = 5'b00010;
    localparam logic [4:0] ARG_DISABLE  = 5'b00011;

    logic [6:0] in_q;
    logic [6:0] in_qq;
    logic [3:0] data_lo;
    logic [3:0] prediv_lo;
    logic [7:0] prediv;
    logic [7:0] count;

    logic       fire;
    logic [1:0] cmd;
    logic [4:0] arg;
    logic       half;
    logic [3:0] nib;
    logic       pop;
    logic       do_data_lo;
    logic       do_push;
    logic       do_pdiv_lo;
    logic       do_pdiv_hi;
    logic       do_soft_rst;
    logic       do_clr_ovf;
    logic       do_enable;
    logic       do_disable;
    logic [7:0] push_byte;
    logic [7:0] new_prediv;

    // A command fires once per bus change; SPARE only re-arms the detector.
    assign fire = (in_q != in_qq) && (in_q[1:0] != CMD_SPARE);
    assign cmd  = in_q[1:0];
    assign arg  = in_q[6:2];
    assign half = in_q[6];
    assign nib  = in_q[5:2];

    assign pop         = tx_valid && tx_ready;
    assign do_data_lo  = fire && (cmd == CMD_DATA)   && !half;
    assign do_push     = fire && (cmd == CMD_DATA)   &&  half;
    assign do_pdiv_lo  = fire && (cmd == CMD_PREDIV) && !half;
    assign do_pdiv_hi  = fire && (cmd == CMD_PREDIV) &&  half;
    assign do_soft_rst = fire && (cmd == CMD_CONFIG) && (arg == ARG_SOFT_RST);
    assign do_clr_ovf  = fire && (cmd == CMD_CONFIG) && (arg == ARG_CLR_OVF);
    assign do_enable   = fire && (cmd == CMD_CONFIG) && (arg == ARG_ENABLE);
    assign do_disable  = fire && (cmd == CMD_CONFIG) && (arg == ARG_DISABLE);
    assign push_byte   = {nib, data_lo};
    assign new_prediv  = {nib, prediv_lo};

    // Bus sampler: only a hardware reset touches it, so a held soft-reset
    // command cannot refire after it executes.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q  <= BUS_IDLE;
            in_qq <= BUS_IDLE;
        end else begin
            in_q  <= in7;
            in_qq <= in_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || do_soft_rst) begin
            tx_data            <= 8'd0;
            tx_valid           <= 1'b0;
            data_lo            <= 4'd0;
            prediv_lo          <= 4'd0;
            prediv             <= 8'd0;
            count              <= 8'd0;
            enable             <= 1'b0;
            overflow           <= 1'b0;
            baud_tick          <= 1'b0;
            resetCommandStrobe <= !reset;
        end else begin
            resetCommandStrobe <= 1'b0;

            if (do_data_lo) data_lo   <= nib;
            if (do_pdiv_lo) prediv_lo <= nib;
            if (do_pdiv_hi) prediv    <= new_prediv;

            // Holding register: a pop in the same cycle frees the slot.
            if (do_push && (!tx_valid || pop)) begin
                tx_data  <= push_byte;
                tx_valid <= 1'b1;
            end else begin
                if (do_push) overflow <= 1'b1;
                if (pop)     tx_valid <= 1'b0;
            end

            // Clear and push are distinct commands, so they never collide.
            if (do_clr_ovf) overflow <= 1'b0;
            if (do_enable)  enable   <= 1'b1;
            if (do_disable) enable   <= 1'b0;

            // Disabling suppresses the tick at the same edge so no pulse
            // appears once enable reads low.
            if (!enable || do_disable) begin
                count     <= prediv;
                baud_tick <= 1'b0;
            end else if (count == 8'd0) begin
                count     <= prediv;
                baud_tick <= 1'b1;
            end else begin
                count     <= count - 8'd1;
                baud_tick <= 1'b0;
            end

            // A new divisor restarts the count immediately.
            if (do_pdiv_hi) count <= new_prediv;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] in7;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       baud_tick;
    logic       enable;
    logic       overflow;
    logic       resetCommandStrobe;

    localparam logic [6:0] SPARE = 7'h7F;

    always #5 clk = ~clk;

    uart_cmd_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .in7               (in7),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .baud_tick         (baud_tick),
        .enable            (enable),
        .overflow          (overflow),
        .resetCommandStrobe(resetCommandStrobe)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: abstract state of the block as seen by the host.
    logic [7:0] exp_bytes[$];
    bit         m_full     = 0;
    int         m_byte     = 0;
    logic [3:0] m_data_lo  = 0;
    logic [3:0] m_pdiv_lo  = 0;
    int         m_prediv   = 0;
    bit         m_enable   = 0;
    bit         m_overflow = 0;
    int         m_strobes  = 0;

    // Monitor state
    bit         started      = 0;
    int         seen_strobes = 0;
    int         tick_seen    = 0;
    int         tcnt         = 0;
    bit         en_prev      = 0;
    bit         strobe_prev  = 0;
    logic [7:0] mon_exp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] mk(input logic [1:0] cmd, input logic [4:0] arg);
        return {arg, cmd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_bytes.delete();
        m_full     = 0;
        m_byte     = 0;
        m_data_lo  = 0;
        m_pdiv_lo  = 0;
        m_prediv   = 0;
        m_enable   = 0;
        m_overflow = 0;
    endtask

    // Issue one command, optionally asserting tx_ready exactly at the
    // firing edge, hold it, then return the bus to SPARE.
    task automatic issue(input logic [6:0] c, input bit simpop, input int hold);
        bit         exp_strobe;
        logic [7:0] b;
        exp_strobe = 0;
        in7 = c;
        step();
        if (simpop) tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        case (c[1:0])
            2'd0: begin
                if (!c[6]) m_data_lo = c[5:2];
                else begin
                    b = {c[5:2], m_data_lo};
                    if (m_full && !simpop) m_overflow = 1;
                    else begin
                        exp_bytes.push_back(b);
                        m_full = 1;
                        m_byte = int'(b);
                    end
                end
            end
            2'd1: begin
                case (c[6:2])
                    5'b11000: begin
                        model_reset();
                        m_strobes++;
                        exp_strobe = 1;
                    end
                    5'b00001: m_overflow = 0;
                    5'b00010: m_enable = 1;
                    5'b00011: m_enable = 0;
                    default: ;
                endcase
            end
            2'd2: begin
                if (!c[6]) m_pdiv_lo = c[5:2];
                else m_prediv = int'({c[5:2], m_pdiv_lo});
            end
            default: ;
        endcase
        chk("strobe", int'(resetCommandStrobe), int'(exp_strobe));
        chk("enable", int'(enable), int'(m_enable));
        chk("overflow", int'(overflow), int'(m_overflow));
        chk("tx_valid", int'(tx_valid), int'(m_full));
        chk("tx_data", int'(tx_data), m_byte);
        repeat (hold) step();
        in7 = SPARE;
        repeat (2) step();
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        m_full = 0;
        chk("drain_valid", int'(tx_valid), 0);
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            if (tx_valid && tx_ready && !reset) begin
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %0h expected none", tx_data);
                end else begin
                    mon_exp = exp_bytes.pop_front();
                    chk("tx_byte", int'(tx_data), int'(mon_exp));
                end
            end
            if (resetCommandStrobe) begin
                seen_strobes++;
                chk("strobe_width", int'(strobe_prev), 0);
            end
            strobe_prev = resetCommandStrobe;
            if (!enable) begin
                chk("tick_when_disabled", int'(baud_tick), 0);
                tcnt = 0;
            end else begin
                if (!en_prev) tcnt = 0;
                else tcnt++;
                if (baud_tick) begin
                    chk("tick_period", tcnt, m_prediv + 1);
                    tick_seen++;
                    tcnt = 0;
                end else if (tcnt > m_prediv + 1) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_tick: got none after %0d cycles expected period %0d", tcnt, m_prediv + 1);
                    tcnt = 0;
                end
            end
            en_prev = enable;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks0;
        int r;
        logic [4:0] a;
        logic [3:0] n;

        reset    = 1'b1;
        in7      = SPARE;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tick", int'(baud_tick), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_strobe", int'(resetCommandStrobe), 0);
        reset = 1'b0;
        started = 1;
        step();

        // Data push A5
        issue(mk(2'd0, {1'b0, 4'h5}), 0, 1);
        issue(mk(2'd0, {1'b1, 4'hA}), 0, 1);
        chk("push_a5", int'(tx_data), 8'hA5);
        // Overflow then clear
        issue(mk(2'd0, {1'b0, 4'hC}), 0, 1);
        issue(mk(2'd0, {1'b1, 4'h3}), 0, 1);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_keep_a5", int'(tx_data), 8'hA5);
        issue(mk(2'd1, 5'b00001), 0, 1);
        chk("ovf_clear", int'(overflow), 0);
        // Simultaneous push and pop
        issue(mk(2'd0, {1'b0, 4'h1}), 0, 1);
        issue(mk(2'd0, {1'b1, 4'hE}), 1, 1);
        chk("simpop_byte", int'(tx_data), 8'hE1);
        chk("simpop_ovf", int'(overflow), 0);
        drain();

        // Baud tick with prediv 3
        issue(mk(2'd2, {1'b0, 4'h3}), 0, 1);
        issue(mk(2'd2, {1'b1, 4'h0}), 0, 1);
        ticks0 = tick_seen;
        issue(mk(2'd1, 5'b00010), 0, 1);
        repeat (20) step();
        chk("ticks_seen", int'(tick_seen - ticks0 >= 5), 1);
        issue(mk(2'd1, 5'b00011), 0, 1);
        ticks0 = tick_seen;
        repeat (10) step();
        chk("ticks_stopped", tick_seen - ticks0, 0);

        // Soft reset with enable, overflow and pending byte, arg held
        issue(mk(2'd1, 5'b00010), 0, 1);
        issue(mk(2'd0, {1'b1, 4'h6}), 0, 1);
        issue(mk(2'd0, {1'b1, 4'h7}), 0, 1);
        issue(mk(2'd1, 5'b11000), 0, 6);
        chk("soft_strobe_count", seen_strobes, 1);

        // Randomized command stream
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            n = 4'($urandom_range(0, 15));
            case (r)
                0, 1: issue(mk(2'd0, {1'b0, n}), 0, $urandom_range(1, 3));
                2, 3: issue(mk(2'd0, {1'b1, n}), m_full && ($urandom_range(0, 1) == 1), $urandom_range(1, 3));
                4: if (m_full) drain();
                5: begin
                    case ($urandom_range(0, 7))
                        0: a = 5'b00001;
                        1, 2: a = 5'b00010;
                        3: a = 5'b00011;
                        4: a = 5'b11000;
                        default: begin
                            a = 5'($urandom_range(0, 31));
                            if (a == 5'b00001 || a == 5'b00010 || a == 5'b00011 || a == 5'b11000)
                                a = 5'b10101;
                        end
                    endcase
                    issue(mk(2'd1, a), 0, $urandom_range(1, 3));
                end
                6: if (!m_enable) issue(mk(2'd2, {1'b0, 4'($urandom_range(0, 7))}), 0, 1);
                7: if (!m_enable)
                       issue(mk(2'd2, {1'b1, ($urandom_range(0, 3) == 0) ? n : 4'h0}), 0, 1);
                8: issue(mk(2'd1, 5'b00010), 0, 1);
                default: repeat ($urandom_range(1, 5)) step();
            endcase
        end

        // Hardware reset during a pending byte and active ticking
        if (m_full) drain();
        issue(mk(2'd1, 5'b00011), 0, 1);
        issue(mk(2'd2, {1'b0, 4'h2}), 0, 1);
        issue(mk(2'd2, {1'b1, 4'h0}), 0, 1);
        issue(mk(2'd0, {1'b0, 4'h7}), 0, 1);
        issue(mk(2'd0, {1'b1, 4'h2}), 0, 1);
        issue(mk(2'd1, 5'b00010), 0, 1);
        repeat (5) step();
        reset = 1'b1;
        in7   = mk(2'd0, {1'b1, 4'h9});
        repeat (2) step();
        model_reset();
        chk("hrst_tx_data", int'(tx_data), 0);
        chk("hrst_tx_valid", int'(tx_valid), 0);
        chk("hrst_tick", int'(baud_tick), 0);
        chk("hrst_enable", int'(enable), 0);
        chk("hrst_overflow", int'(overflow), 0);
        chk("hrst_strobe", int'(resetCommandStrobe), 0);
        reset = 1'b0;
        repeat (2) step();
        exp_bytes.push_back(8'h90);
        m_full = 1;
        m_byte = 8'h90;
        chk("post_rst_byte", int'(tx_data), 8'h90);
        chk("post_rst_valid", int'(tx_valid), 1);
        repeat (4) step();
        chk("post_rst_no_refire", int'(overflow), 0);
        drain();
        repeat (3) step();
        chk("post_rst_idle", int'(tx_valid), 0);
        in7 = SPARE;
        repeat (3) step();

        chk("queue_empty", exp_bytes.size(), 0);
        chk("strobe_count", seen_strobes, m_strobes);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
